// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: pipeline status in, PC/IF-ID/ID-EX hold, bubble and flush controls out.
// master = pipeline datapath side, slave = hazard sequencer.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic             ex_valid;
  logic [4:0]       ex_rd;
  logic             ex_is_load;
  logic             ex_is_mc;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             hold_pc;
  logic             hold_ifid;
  logic             hold_idex;
  logic             bubble_idex;
  logic             flush_ifid;
  logic             mc_busy;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output ex_valid, ex_rd, ex_is_load, ex_is_mc, branch_taken,
    output mem_req, mem_ready,
    input  hold_pc, hold_ifid, hold_idex, bubble_idex, flush_ifid,
    input  mc_busy, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  ex_valid, ex_rd, ex_is_load, ex_is_mc, branch_taken,
    input  mem_req, mem_ready,
    output hold_pc, hold_ifid, hold_idex, bubble_idex, flush_ifid,
    output mc_busy, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; controls are combinational so a stall
// acts at the same edge. Memory stalls freeze everything, including the multi-cycle countdown.
module pipeline_hazard_ctrl #(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [0:0]       RUN      = 1'b0;
  localparam logic [0:0]       MC_WAIT  = 1'b1;
  localparam logic [7:0]       MC_INIT  = 8'(MC_LAT - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [0:0]       state_q, state_d;
  logic [7:0]       mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic mem_stall, load_use, rs1_hit, rs2_hit;
  logic hold_pc, hold_ifid, hold_idex, bubble_idex, flush_ifid;

  assign mem_stall = hz.mem_req & ~hz.mem_ready;
  assign rs1_hit   = hz.id_rs1_used & (hz.id_rs1 == hz.ex_rd);
  assign rs2_hit   = hz.id_rs2_used & (hz.id_rs2 == hz.ex_rd);
  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use  = hz.ex_valid & hz.ex_is_load & (hz.ex_rd != 5'd0) &
                     hz.id_valid & (rs1_hit | rs2_hit);

  always_comb begin
    state_d     = state_q;
    mc_cnt_d    = mc_cnt_q;
    hold_pc     = 1'b0;
    hold_ifid   = 1'b0;
    hold_idex   = 1'b0;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;

    if (mem_stall) begin
      hold_pc   = 1'b1;
      hold_ifid = 1'b1;
      hold_idex = 1'b1;
    end else if (state_q == MC_WAIT) begin
      if (mc_cnt_q != 8'd0) begin
        hold_pc   = 1'b1;
        hold_ifid = 1'b1;
        hold_idex = 1'b1;
        mc_cnt_d  = mc_cnt_q - 8'd1;
      end else begin
        state_d = RUN;
      end
    end else if (hz.ex_valid & hz.ex_is_mc) begin
      // Detection cycle counts toward occupancy, hence MC_LAT-2 further held cycles.
      hold_pc   = 1'b1;
      hold_ifid = 1'b1;
      hold_idex = 1'b1;
      mc_cnt_d  = MC_INIT;
      state_d   = MC_WAIT;
    end else if (hz.branch_taken) begin
      flush_ifid  = 1'b1;
      bubble_idex = 1'b1;
    end else if (load_use) begin
      hold_pc     = 1'b1;
      hold_ifid   = 1'b1;
      bubble_idex = 1'b1;
    end

    stall_count_d = stall_count_q;
    if (hold_pc && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      mc_cnt_q      <= 8'd0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      mc_cnt_q      <= mc_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign hz.hold_pc     = hold_pc;
  assign hz.hold_ifid   = hold_ifid;
  assign hz.hold_idex   = hold_idex;
  assign hz.bubble_idex = bubble_idex;
  assign hz.flush_ifid  = flush_ifid;
  assign hz.mc_busy     = (state_q == MC_WAIT);
  assign hz.stall_count = stall_count_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage integer pipeline.
- Watches the ID stage, the EX stage (including multi-cycle ALU ops), the branch-resolve result in EX, and the data-memory handshake.
- Drives the hold, bubble and flush controls of the PC, the IF/ID register and the ID/EX register.
- A bubble loads ID/EX with a NOP: alu_type=0, rd=0.

Parameters:
- MC_LAT, 4, EX occupancy in cycles of a multi-cycle op (mul/div). Legal range 2..255.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- ex_valid  in  1  EX stage holds a real instruction
- ex_rd  in  5  EX destination register
- ex_is_load  in  1  EX instruction is a load
- ex_is_mc  in  1  EX instruction is multi-cycle
- branch_taken  in  1  EX resolved a taken branch or jump
- mem_req  in  1  MEM stage access active
- mem_ready  in  1  data memory completes the access this cycle
- hold_pc  out  1  PC keeps its value
- hold_ifid  out  1  IF/ID keeps its value
- hold_idex  out  1  ID/EX keeps its value
- bubble_idex  out  1  ID/EX loads a NOP at the next edge
- flush_ifid  out  1  IF/ID loads a NOP at the next edge
- mc_busy  out  1  multi-cycle wait in progress
- stall_count  out  CNT_W  cycles with hold_pc=1, saturating

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset state: state=RUN, mc_cnt=0, stall_count=0.
- Outputs in reset: mc_busy=0. All combinational outputs are 0, given idle inputs.
- State register: 2 states, RUN and MC_WAIT. Internal counter mc_cnt is 8 bits.
- Hold/bubble/flush outputs are combinational from the current state and inputs, so a stall takes effect at the same edge.
- mc_busy = (state==MC_WAIT), registered.

- Signal definitions:
  - mem_stall = mem_req & ~mem_ready.
  - load_use = ex_valid & ex_is_load & (ex_rd!=0) & id_valid & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).

- Priority each cycle, first match wins:
  1. mem_stall:
     - hold_pc=hold_ifid=hold_idex=1; bubble_idex=flush_ifid=0.
     - state and mc_cnt frozen.
  2. state==MC_WAIT:
     - If mc_cnt!=0: hold_pc=hold_ifid=hold_idex=1; mc_cnt decrements.
     - If mc_cnt==0: no holds (the pipeline advances at this edge); next state RUN.
  3. RUN & ex_valid & ex_is_mc:
     - hold_pc=hold_ifid=hold_idex=1; mc_cnt<=MC_LAT-2; next state MC_WAIT.
     - Total EX occupancy is exactly MC_LAT cycles.
     - branch_taken in the same cycle is ignored; mc ops never branch.
  4. RUN & branch_taken:
     - flush_ifid=1, bubble_idex=1; no holds.
     - Both wrong-path instructions are killed in one cycle.
     - Branch beats load_use.
  5. RUN & load_use:
     - hold_pc=hold_ifid=1, bubble_idex=1 for exactly one cycle.
     - The next cycle re-evaluates; the load has moved on, so no repeat stall.
  6. Otherwise all control outputs are 0.

- Invariants:
  - hold_idex and bubble_idex are never both 1.
  - flush_ifid implies hold_ifid=0.
- stall_count increments at each edge where hold_pc=1. It saturates at 2^CNT_W-1 and never wraps.
- Reset mid-MC_WAIT: returns to RUN asynchronously; mc_cnt=0; all holds drop once rst asserts.
- Back-to-back mc ops: the second is detected in RUN on the cycle after release, giving a fresh MC_LAT wait.
- An ex_rd of x0 never causes a stall.

Test Plan:
- Reset with all inputs 0: every output 0, stall_count=0; pulse rst during MC_WAIT -> mc_busy=0 immediately.
- Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_rs2_used=1 -> one cycle of hold_pc=hold_ifid=bubble_idex=1, then all 0; stall_count=1.
- Same as above but ex_rd=0, or id_rs2_used=0 -> no stall.
- Multi-cycle op, MC_LAT=4: ex_is_mc=1 -> holds asserted for cycles 0..2, released in cycle 3; mc_busy=1 for cycles 1..3; stall_count=3.
- branch_taken=1 together with a load_use condition -> flush_ifid=bubble_idex=1, hold_pc=0, stall_count unchanged.
- mem_req=1, mem_ready=0 for 3 cycles arriving mid-MC_WAIT (mc_cnt=1) -> all holds for 3 cycles, mc_cnt frozen at 1; after mem_ready=1, release occurs 2 cycles later.
- Force hold_pc for 2^CNT_W+5 cycles with CNT_W=4 -> stall_count sticks at 15.
